// File: rtl/enemy_pool_pkg.sv
// Shared definitions for the obstacle pool: kind encodings, sprite sizes,
// vertical placement, LFSR seed/taps and spawner state encodings.
package enemy_pool_pkg;

  typedef enum logic [1:0] {
    KIND_SMALL = 2'd0,
    KIND_LARGE = 2'd1,
    KIND_BIRD  = 2'd2
  } kind_e;

  localparam logic [7:0] SMALL_W = 8'd17;
  localparam logic [7:0] SMALL_H = 8'd35;
  localparam logic [7:0] LARGE_W = 8'd25;
  localparam logic [7:0] LARGE_H = 8'd50;
  localparam logic [7:0] BIRD_W  = 8'd46;
  localparam logic [7:0] BIRD_H  = 8'd40;

  localparam int GROUND_Y    = 400;
  localparam int BIRD_Y_HIGH = 300;
  localparam int BIRD_Y_LOW  = 350;

  // Galois form of x^16 + x^14 + x^13 + x^11
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    SP_GAP   = 1'b0,
    SP_ARMED = 1'b1
  } spawn_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/enemy_pool_if.sv
// Obstacle pool bus: game control inputs (pause/clear) plus the flat
// per-slot buses consumed by the renderer and collision logic.
//   master : the pool (receives pause/clear, drives slot buses)
//   slave  : game/renderer side
interface enemy_pool_if #(
  parameter int SLOTS = 4,
  parameter int XW    = 10,
  parameter int YW    = 9
);
  logic                  pause;
  logic                  clear;
  logic [SLOTS-1:0]      obj_valid;
  logic [2*SLOTS-1:0]    obj_kind;
  logic [XW*SLOTS-1:0]   obj_x;
  logic [YW*SLOTS-1:0]   obj_y;
  logic [8*SLOTS-1:0]    obj_w;
  logic [8*SLOTS-1:0]    obj_h;
  logic [3:0]            speed;
  logic                  spawn_pulse;
  logic [7:0]            stall_cnt;

  modport master (
    input  pause, clear,
    output obj_valid, obj_kind, obj_x, obj_y, obj_w, obj_h,
    output speed, spawn_pulse, stall_cnt
  );

  modport slave (
    output pause, clear,
    input  obj_valid, obj_kind, obj_x, obj_y, obj_w, obj_h,
    input  speed, spawn_pulse, stall_cnt
  );
endinterface

// File: rtl/enemy_spawn_ctrl.sv
// Spawn controller: LFSR, inter-spawn gap down-counter, GAP/ARMED FSM,
// kind/y/size selection for the next obstacle and the stall counter.
// Ports: clk3/reset, pause/clear, speed (current px/frame), slot_free
// (some slot is free this edge); outputs spawn_req (combinational, take
// the lowest free slot this edge) plus attributes, spawn_pulse, stall_cnt.
//
//   state    | meaning
//   SP_GAP   | counting gap_cnt down to 0 between spawns
//   SP_ARMED | spawn on the next edge with a free slot, else count a stall
module enemy_spawn_ctrl
  import enemy_pool_pkg::*;
#(
  parameter int YW         = 9,
  parameter int GAP_MIN    = 40,
  parameter int BIRD_SPEED = 4
) (
  input  logic          clk3,
  input  logic          reset,
  input  logic          pause,
  input  logic          clear,
  input  logic [3:0]    speed,
  input  logic          slot_free,
  output logic          spawn_req,
  output kind_e         spawn_kind,
  output logic [YW-1:0] spawn_y,
  output logic [7:0]    spawn_w,
  output logic [7:0]    spawn_h,
  output logic          spawn_pulse,
  output logic [7:0]    stall_cnt
);

  localparam int GW = $clog2(GAP_MIN + 64);

  spawn_state_e  state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [7:0]    stall_cnt_q, stall_cnt_d;
  logic          spawn_pulse_q, spawn_pulse_d;
  logic [GW-1:0] gap_load;

  assign gap_load = GW'(GAP_MIN) + GW'(lfsr_q[5:0]);

  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    lfsr_d        = lfsr_q;
    stall_cnt_d   = stall_cnt_q;
    spawn_pulse_d = 1'b0;
    spawn_req     = 1'b0;
    if (clear) begin
      state_d     = SP_GAP;
      gap_cnt_d   = GW'(GAP_MIN);
      stall_cnt_d = 8'd0;
    end else if (!pause) begin
      lfsr_d = lfsr_next(lfsr_q);
      case (state_q)
        SP_GAP: begin
          // gap_cnt can sit at 0 in GAP only when GAP_MIN is 0 out of reset
          if (gap_cnt_q <= GW'(1)) state_d = SP_ARMED;
          if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - 1'b1;
        end
        SP_ARMED: begin
          if (slot_free) begin
            spawn_req     = 1'b1;
            spawn_pulse_d = 1'b1;
            gap_cnt_d     = gap_load;
            state_d       = (gap_load == '0) ? SP_ARMED : SP_GAP;
          end else if (stall_cnt_q != 8'hFF) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
          end
        end
        default: state_d = SP_GAP;
      endcase
    end
  end

  // Attribute selection from the current (pre-advance) LFSR value
  always_comb begin
    spawn_kind = KIND_SMALL;
    spawn_w    = SMALL_W;
    spawn_h    = SMALL_H;
    spawn_y    = YW'(GROUND_Y - int'(SMALL_H));
    if (lfsr_q[1:0] == 2'd2 ||
        (lfsr_q[1:0] == 2'd3 && speed < 4'(BIRD_SPEED))) begin
      spawn_kind = KIND_LARGE;
      spawn_w    = LARGE_W;
      spawn_h    = LARGE_H;
      spawn_y    = YW'(GROUND_Y - int'(LARGE_H));
    end else if (lfsr_q[1:0] == 2'd3) begin
      spawn_kind = KIND_BIRD;
      spawn_w    = BIRD_W;
      spawn_h    = BIRD_H;
      spawn_y    = lfsr_q[2] ? YW'(BIRD_Y_HIGH) : YW'(BIRD_Y_LOW);
    end
  end

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      state_q       <= SP_GAP;
      gap_cnt_q     <= GW'(GAP_MIN);
      lfsr_q        <= LFSR_SEED;
      stall_cnt_q   <= 8'd0;
      spawn_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      lfsr_q        <= lfsr_d;
      stall_cnt_q   <= stall_cnt_d;
      spawn_pulse_q <= spawn_pulse_d;
    end
  end

  assign spawn_pulse = spawn_pulse_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: rtl/enemy_pool.sv
// Obstacle pool for the dinosaur game. Each unpaused clk3 edge is a frame:
// active slots scroll left by the current speed and retire at the left
// edge; the spawn controller fills the lowest free slot.
// Ports: clk3 (frame clock), reset (async, active-low),
//        bus (enemy_pool_if.master: pause/clear in, slot buses,
//        speed, spawn_pulse, stall_cnt out).
module enemy_pool
  import enemy_pool_pkg::*;
#(
  parameter int SLOTS      = 4,
  parameter int XW         = 10,
  parameter int YW         = 9,
  parameter int SCREEN_W   = 640,
  parameter int SPEED_INIT = 2,
  parameter int SPEED_MAX  = 8,
  parameter int SPEED_STEP = 512,
  parameter int GAP_MIN    = 40,
  parameter int BIRD_SPEED = 4
) (
  input  logic         clk3,
  input  logic         reset,
  enemy_pool_if.master bus
);

  localparam int FW = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  if (SCREEN_W >= (1 << XW)) begin : g_screen_w_check
    $error("SCREEN_W does not fit in XW bits");
  end

  logic [SLOTS-1:0]          valid_q, valid_d;
  logic [SLOTS-1:0][1:0]     kind_q, kind_d;
  logic [SLOTS-1:0][XW-1:0]  x_q, x_d;
  logic [SLOTS-1:0][YW-1:0]  y_q, y_d;
  logic [SLOTS-1:0][7:0]     w_q, w_d, h_q, h_d;
  logic [3:0]                speed_q, speed_d;
  logic [FW-1:0]             frame_cnt_q, frame_cnt_d;

  logic          free_any;
  logic [IW-1:0] free_idx;
  logic          spawn_req;
  kind_e         spawn_kind;
  logic [YW-1:0] spawn_y;
  logic [7:0]    spawn_w, spawn_h;
  logic [XW-1:0] spd_x;
  logic          frame_wrap;

  // Lowest-index free slot, from registered valid only: a slot retiring
  // on this edge becomes free on the next one.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  enemy_spawn_ctrl #(
    .YW        (YW),
    .GAP_MIN   (GAP_MIN),
    .BIRD_SPEED(BIRD_SPEED)
  ) u_spawn (
    .clk3       (clk3),
    .reset      (reset),
    .pause      (bus.pause),
    .clear      (bus.clear),
    .speed      (speed_q),
    .slot_free  (free_any),
    .spawn_req  (spawn_req),
    .spawn_kind (spawn_kind),
    .spawn_y    (spawn_y),
    .spawn_w    (spawn_w),
    .spawn_h    (spawn_h),
    .spawn_pulse(bus.spawn_pulse),
    .stall_cnt  (bus.stall_cnt)
  );

  assign spd_x      = XW'(speed_q);
  assign frame_wrap = (frame_cnt_q == FW'(SPEED_STEP - 1));

  always_comb begin
    valid_d     = valid_q;
    kind_d      = kind_q;
    x_d         = x_q;
    y_d         = y_q;
    w_d         = w_q;
    h_d         = h_q;
    speed_d     = speed_q;
    frame_cnt_d = frame_cnt_q;
    if (bus.clear) begin
      valid_d     = '0;
      kind_d      = '0;
      x_d         = '0;
      y_d         = '0;
      w_d         = '0;
      h_d         = '0;
      speed_d     = 4'(SPEED_INIT);
      frame_cnt_d = '0;
    end else if (!bus.pause) begin
      frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + 1'b1;
      if (frame_wrap && speed_q < 4'(SPEED_MAX)) speed_d = speed_q + 4'd1;
      for (int i = 0; i < SLOTS; i++) begin
        if (valid_q[i]) begin
          if (x_q[i] < spd_x) valid_d[i] = 1'b0;
          else                x_d[i]     = x_q[i] - spd_x;
        end
      end
      // The spawn target was invalid, so it never collides with movement.
      if (spawn_req) begin
        valid_d[free_idx] = 1'b1;
        kind_d[free_idx]  = spawn_kind;
        x_d[free_idx]     = XW'(SCREEN_W);
        y_d[free_idx]     = spawn_y;
        w_d[free_idx]     = spawn_w;
        h_d[free_idx]     = spawn_h;
      end
    end
  end

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      valid_q     <= '0;
      kind_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      speed_q     <= 4'(SPEED_INIT);
      frame_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      kind_q      <= kind_d;
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      speed_q     <= speed_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.obj_valid = valid_q;
  assign bus.obj_kind  = kind_q;
  assign bus.obj_x     = x_q;
  assign bus.obj_y     = y_q;
  assign bus.obj_w     = w_q;
  assign bus.obj_h     = h_q;
  assign bus.speed     = speed_q;

endmodule
